// File: rtl/phase_sequencer.sv
// Four-phase timed sequencer: captures per-phase durations on start and
// counts each phase down in prescaled ticks, with hold, abort and looping.
//
// state | meaning
// IDLE  | waiting for start, outputs at rest
// RUN   | prescaler and remaining count advance
// HOLD  | timing frozen while hold is high
module phase_sequencer #(
  parameter int DATAWIDTH = 4,
  parameter int PRESCALE  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 hold_i,
  input  logic                 abort_i,
  input  logic                 loop_i,
  input  logic [DATAWIDTH-1:0] dur0_i,
  input  logic [DATAWIDTH-1:0] dur1_i,
  input  logic [DATAWIDTH-1:0] dur2_i,
  input  logic [DATAWIDTH-1:0] dur3_i,
  output logic [1:0]           phase_o,
  output logic [DATAWIDTH-1:0] remaining_o,
  output logic                 busy_o,
  output logic                 phase_done_o,
  output logic                 seq_done_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [1:0]           phase_q, phase_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 pdone_q, pdone_d;
  logic                 sdone_q, sdone_d;
  logic [DATAWIDTH-1:0] dur0_q, dur1_q, dur2_q, dur3_q;
  logic [DATAWIDTH-1:0] dur0_d, dur1_d, dur2_d, dur3_d;
  logic [DATAWIDTH-1:0] next_dur;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      pdone_q <= 1'b0;
      sdone_q <= 1'b0;
      dur0_q  <= '0;
      dur1_q  <= '0;
      dur2_q  <= '0;
      dur3_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      pdone_q <= pdone_d;
      sdone_q <= sdone_d;
      dur0_q  <= dur0_d;
      dur1_q  <= dur1_d;
      dur2_q  <= dur2_d;
      dur3_q  <= dur3_d;
    end
  end

  always_comb begin
    case (phase_q)
      2'd0:    next_dur = dur1_q;
      2'd1:    next_dur = dur2_q;
      default: next_dur = dur3_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    pdone_d = 1'b0;
    sdone_d = 1'b0;
    dur0_d  = dur0_q;
    dur1_d  = dur1_q;
    dur2_d  = dur2_q;
    dur3_d  = dur3_q;

    if (abort_i) begin
      state_d = S_IDLE;
      presc_d = '0;
      phase_d = '0;
      rem_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_RUN;
            presc_d = '0;
            phase_d = '0;
            rem_d   = dur0_i;
            busy_d  = 1'b1;
            dur0_d  = dur0_i;
            dur1_d  = dur1_i;
            dur2_d  = dur2_i;
            dur3_d  = dur3_i;
          end
        end
        S_RUN, S_HOLD: begin
          if (hold_i) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_RUN;
            if (presc_q == PS_LAST) begin
              presc_d = '0;
              // remaining of 0 or 1 both end the phase on this tick
              if (rem_q > DATAWIDTH'(1)) begin
                rem_d = rem_q - DATAWIDTH'(1);
              end else begin
                pdone_d = 1'b1;
                if (phase_q != 2'd3) begin
                  phase_d = phase_q + 2'd1;
                  rem_d   = next_dur;
                end else begin
                  sdone_d = 1'b1;
                  phase_d = '0;
                  if (loop_i) begin
                    rem_d = dur0_q;
                  end else begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                  end
                end
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign phase_o      = phase_q;
  assign remaining_o  = rem_q;
  assign busy_o       = busy_q;
  assign phase_done_o = pdone_q;
  assign seq_done_o   = sdone_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected outputs are queued per edge
// offset from the start edge and compared just after each rising edge.
module tb_phase_sequencer;

  localparam int DW = 4;
  localparam int PS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hold = 1'b0, abort = 1'b0, lp = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [1:0] phase_o;
  logic [DW-1:0] remaining_o;
  logic busy_o, phase_done_o, seq_done_o;

  phase_sequencer #(.DATAWIDTH(DW), .PRESCALE(PS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold),
    .abort_i(abort), .loop_i(lp), .dur0_i(d0), .dur1_i(d1), .dur2_i(d2),
    .dur3_i(d3), .phase_o(phase_o), .remaining_o(remaining_o),
    .busy_o(busy_o), .phase_done_o(phase_done_o), .seq_done_o(seq_done_o)
  );

  always #5 clk = ~clk;

  // signal ids: 0 phase, 1 remaining, 2 busy, 3 phase_done, 4 seq_done
  typedef struct {
    int    at;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int obs(input int sig);
    case (sig)
      0:       return int'(phase_o);
      1:       return int'(remaining_o);
      2:       return int'(busy_o);
      3:       return int'(phase_done_o);
      default: return int'(seq_done_o);
    endcase
  endfunction

  task automatic push(input int at, input int sig, input int val, input string tag);
    exp_t e;
    e.at = at; e.sig = sig; e.val = val; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic push_strobes(input int first, input int last, input int sig,
                              input string nm, input int h0, input int h1,
                              input int h2, input int h3, input int h4);
    for (int c = first; c <= last; c++)
      push(c, sig, (c == h0 || c == h1 || c == h2 || c == h3 || c == h4) ? 1 : 0,
           $sformatf("%s@%0d", nm, c));
  endtask

  task automatic drain();
    exp_t keep[$];
    foreach (sbq[i]) begin
      if (sbq[i].at == cyc) chk_eq(sbq[i].tag, obs(sbq[i].sig), sbq[i].val);
      else keep.push_back(sbq[i]);
    end
    sbq = keep;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  task automatic do_start(input int a, input int b, input int c, input int d, input logic l);
    d0 = DW'(a); d1 = DW'(b); d2 = DW'(c); d3 = DW'(d); lp = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    drain();
  endtask

  task automatic do_abort(input string nm);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk_eq({nm, "_abort_busy"},  int'(busy_o), 0);
    chk_eq({nm, "_abort_phase"}, int'(phase_o), 0);
    chk_eq({nm, "_abort_rem"},   int'(remaining_o), 0);
    chk_eq({nm, "_abort_pd"},    int'(phase_done_o), 0);
    chk_eq({nm, "_abort_sd"},    int'(seq_done_o), 0);
  endtask

  task automatic sb_end(input string nm);
    chk_eq({nm, "_sb_leftover"}, sbq.size(), 0);
    sbq.delete();
  endtask

  // durations 3,1,0,2 at PRESCALE 2, edges 0..13
  task automatic sched_a(input string p);
    push(0, 2, 1, {p, "_busy0"});
    push(0, 0, 0, {p, "_ph0"});
    push(0, 1, 3, {p, "_rem0"});
    push(1, 1, 3, {p, "_rem1"});
    push(2, 1, 2, {p, "_rem2"});
    push(4, 1, 1, {p, "_rem4"});
    push(6, 0, 1, {p, "_ph6"});
    push(6, 1, 1, {p, "_rem6"});
    push(8, 0, 2, {p, "_ph8"});
    push(8, 1, 0, {p, "_rem8_zero_dur"});
    push(10, 0, 3, {p, "_ph10"});
    push(10, 1, 2, {p, "_rem10"});
    push(12, 1, 1, {p, "_rem12"});
    push(13, 2, 1, {p, "_busy13"});
  endtask

  task automatic sched_a_end(input string p);
    push(14, 2, 0, {p, "_busy14"});
    push(14, 0, 0, {p, "_ph14"});
    push(14, 1, 0, {p, "_rem14"});
    push_strobes(1, 16, 3, {p, "_pd"}, 6, 8, 10, 14, -1);
    push_strobes(1, 16, 4, {p, "_sd"}, 14, -1, -1, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk_eq("rst_phase", int'(phase_o), 0);
    chk_eq("rst_rem",   int'(remaining_o), 0);
    chk_eq("rst_busy",  int'(busy_o), 0);
    chk_eq("rst_pd",    int'(phase_done_o), 0);
    chk_eq("rst_sd",    int'(seq_done_o), 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single pass, loop=0
    sched_a("A");
    sched_a_end("A");
    do_start(3, 1, 0, 2, 1'b0);
    repeat (16) step();
    sb_end("A");

    // looping pass
    sched_a("B");
    push(14, 4, 1, "B_sd14");
    push(14, 0, 0, "B_ph14");
    push(14, 1, 3, "B_rem14");
    push(14, 2, 1, "B_busy14");
    push(16, 1, 2, "B_rem16");
    push(20, 0, 1, "B_ph20");
    push_strobes(1, 20, 3, "B_pd", 6, 8, 10, 14, 20);
    push_strobes(1, 20, 4, "B_sd", 14, -1, -1, -1, -1);
    do_start(3, 1, 0, 2, 1'b1);
    repeat (20) step();
    lp = 1'b0;
    do_abort("B");
    sb_end("B");

    // hold for 5 edges starting at edge 3
    for (int c = 0; c <= 10; c++)
      push(c, 1, (c < 2) ? 3 : (c < 9) ? 2 : 1, $sformatf("C_rem@%0d", c));
    push(5, 2, 1, "C_busy_hold");
    push(11, 0, 1, "C_ph11");
    push(11, 1, 1, "C_rem11");
    push(13, 0, 2, "C_ph13");
    push(15, 0, 3, "C_ph15");
    push(17, 0, 0, "C_ph17");
    push(17, 2, 0, "C_busy17");
    push_strobes(1, 18, 3, "C_pd", 11, 13, 15, 17, -1);
    push_strobes(1, 18, 4, "C_sd", 17, -1, -1, -1, -1);
    do_start(3, 1, 1, 1, 1'b0);
    step(); step();
    hold = 1'b1;
    repeat (5) step();
    hold = 1'b0;
    repeat (11) step();
    sb_end("C");

    // abort and start together during phase 2, then restart one edge later
    push(8, 0, 2, "D_ph8");
    push_strobes(1, 9, 3, "D_pd", 6, 8, -1, -1, -1);
    push(9, 2, 0, "D_busy9");
    push(9, 0, 0, "D_ph9");
    push(9, 1, 0, "D_rem9");
    push(9, 4, 0, "D_sd9");
    do_start(3, 1, 0, 2, 1'b0);
    repeat (8) step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    sb_end("D");
    push(0, 2, 1, "D2_busy0");
    push(0, 0, 0, "D2_ph0");
    push(0, 1, 3, "D2_rem0");
    push(2, 1, 2, "D2_rem2");
    do_start(3, 1, 0, 2, 1'b0);
    step(); step();
    do_abort("D2");
    sb_end("D2");
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk_eq("E_idle_start_abort_busy", int'(busy_o), 0);
    chk_eq("E_idle_start_abort_rem", int'(remaining_o), 0);

    // start and new durations while busy are ignored
    sched_a("F");
    sched_a_end("F");
    do_start(3, 1, 0, 2, 1'b0);
    repeat (3) step();
    start = 1'b1;
    d0 = 4'd15; d1 = 4'd15; d2 = 4'd15; d3 = 4'd15;
    step();
    start = 1'b0;
    repeat (12) step();
    sb_end("F");

    // async reset between edges
    do_start(5, 5, 5, 5, 1'b0);
    step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk_eq("G_rst_phase", int'(phase_o), 0);
    chk_eq("G_rst_rem",   int'(remaining_o), 0);
    chk_eq("G_rst_busy",  int'(busy_o), 0);
    #1 rst_n = 1'b1;
    push(0, 1, 2, "G2_rem0");
    push(1, 1, 2, "G2_rem1");
    push(2, 1, 1, "G2_rem2");
    do_start(2, 1, 1, 1, 1'b0);
    step(); step();
    do_abort("G2");
    sb_end("G2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Timed phase sequencer that drives a four-phase cycle with per-phase durations measured in prescaled ticks. It owns the down-counting timing datapath and the control FSM. It exposes the current phase, the remaining ticks, and one-cycle completion strobes to downstream display and actuator logic. It sits between the user control inputs (start/hold/abort) and the blocks that react to phase changes.

## Interface
- DATAWIDTH, 4, width of duration inputs and `remaining`
- PRESCALE, 4, clk cycles per tick (≥1); prescaler width = $clog2(PRESCALE), min 1
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- start  input  1  sampled in IDLE only; begins a sequence
- hold  input  1  level; freezes timing while high (RUN/HOLD only)
- abort  input  1  sampled every cycle; returns to IDLE, highest priority
- loop  input  1  level, sampled at end of phase 3; 1 = restart at phase 0
- dur0..dur3  input  DATAWIDTH each  phase durations in ticks, captured on start
- phase  output  2  current phase index
- remaining  output  DATAWIDTH  ticks left in current phase
- busy  output  1  high in RUN or HOLD
- phase_done  output  1  one-cycle strobe at end of every phase
- seq_done  output  1  one-cycle strobe at end of phase 3

## Operation
- States: IDLE, RUN, HOLD. All outputs are registered.
- Reset (rst low, async): state IDLE, phase=0, remaining=0, busy=0, phase_done=0, seq_done=0, prescaler=0, captured durations=0.
- Priority each edge: abort > hold > tick > start.
- IDLE: start=1 → RUN; phase=0; remaining=dur0; prescaler=0; dur0..dur3 latched into internal registers.
  - Later changes on dur inputs have no effect until the next start.
- RUN: the prescaler counts 0..PRESCALE-1. At PRESCALE-1 a tick fires and the prescaler wraps to 0.
- Tick with remaining>1: remaining decrements by 1.
- Tick with remaining≤1: the phase ends.
  - phase_done=1 for that cycle.
  - If phase<3: phase+1, remaining=dur of next phase.
  - If phase=3: seq_done=1.
    - loop=1: phase=0, remaining=dur0, stay RUN.
    - loop=0: IDLE, phase=0, remaining=0, busy=0.
- A duration of 0 behaves as 1 tick. remaining shows 0 for that phase.
- hold=1 in RUN → HOLD. In HOLD, prescaler, remaining and phase are frozen and no tick fires. hold=0 → RUN, and the prescaler resumes from its frozen value.
- hold is ignored in IDLE.
- abort=1 in any state → IDLE on the next edge with reset values on all outputs (durations kept). No phase_done or seq_done is emitted.
- start is ignored while busy=1. start and abort in the same cycle in IDLE → stays IDLE.
- Strobes are never high for two consecutive cycles unless PRESCALE=1 and consecutive phases have duration ≤1.

## Timing
- start sampled at edge E0 → busy=1, phase=0, remaining=dur0 visible after E0.
- First tick occurs at edge E0+PRESCALE.
- A phase of duration D (D≥1) lasts exactly D·PRESCALE cycles in RUN. The phase_done edge coincides with the load of the next phase.
- Sequence length without hold is (Σ max(dur_i,1))·PRESCALE cycles from E0 to the seq_done edge. busy falls on that same edge when loop=0.
- Each cycle spent in HOLD extends the sequence by exactly 1 cycle.
- abort asserted at edge A → outputs at reset values after A. start is accepted again at edge A+1.

## Test plan
- Reset mid-RUN (rst pulsed low between edges) → phase=0, remaining=0, busy=0 immediately, without waiting for clk.
- PRESCALE=2, dur=3,1,0,2, loop=0, start at E0:
  - remaining 3→2→1 at E0+2/+4.
  - phase_done at E0+6, E0+8, E0+10, E0+14.
  - seq_done and busy=0 at E0+14.
  - phase 2 shows remaining=0.
- Same durations with loop=1:
  - at E0+14: seq_done=1, phase=0, remaining=3, busy stays 1.
  - next phase_done at E0+20.
- hold high for 5 cycles starting E0+3 (PRESCALE=2, dur0=3):
  - remaining frozen during hold.
  - first phase_done at E0+11.
  - remaining fields resume correctly.
- abort together with start during phase 2 → IDLE next edge, all outputs 0, no strobes, start not accepted. A start one cycle later begins a new sequence normally.
- start pulsed and dur0..dur3 changed to 15 while busy → no restart; the sequence completes with the originally captured durations.
